// File: rtl/garage_pkg.sv
// Shared types and default door geometry for the garage door plant and the controller bench.
package garage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2,
    FAULT   = 2'd3
  } door_state_e;

  localparam int unsigned DEF_TRAVEL   = 16;
  localparam int unsigned DEF_STEP_DIV = 4;

endpackage

// File: rtl/garage_door_plant_step_divider.sv
// Motor step divider: one-cycle tick every STEP_DIV enabled cycles, restartable by clear.
module step_divider #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == CW'(STEP_DIV - 1));
  assign tick_c  = enable && !clear && at_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/garage_door_plant.sv
// Behavioural garage door: motor commands in, limit switches and saturating position out.
module garage_door_plant
  import garage_pkg::*;
#(
  parameter int unsigned TRAVEL   = DEF_TRAVEL,
  parameter int unsigned STEP_DIV = DEF_STEP_DIV,
  parameter int unsigned PW       = $clog2(TRAVEL + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          UP_M,
  input  logic          DN_M,
  input  logic          fault_clr,
  output logic          Up_Max,
  output logic          Dn_Max,
  output logic [PW-1:0] position,
  output logic          moving,
  output logic          fault
);

  door_state_e   state;
  door_state_e   nxt_state;
  logic [PW-1:0] nxt_pos;
  logic          div_en;
  logic          step_tick;

  // Command decode; both commands high wins over every other transition.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (UP_M && DN_M)      nxt_state = FAULT;
        else if (UP_M)         nxt_state = RISING;
        else if (DN_M)         nxt_state = FALLING;
      end
      RISING: begin
        if (UP_M && DN_M)      nxt_state = FAULT;
        else if (DN_M)         nxt_state = FALLING;
        else if (!UP_M)        nxt_state = IDLE;
      end
      FALLING: begin
        if (UP_M && DN_M)      nxt_state = FAULT;
        else if (UP_M)         nxt_state = RISING;
        else if (!DN_M)        nxt_state = IDLE;
      end
      FAULT: begin
        if (fault_clr && !UP_M && !DN_M) nxt_state = IDLE;
      end
      default:                 nxt_state = IDLE;
    endcase
  end

  // Divider only runs while the motor keeps the same direction across the edge.
  assign div_en = ((state == RISING) || (state == FALLING)) && (nxt_state == state);

  step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!div_en),
    .enable  (div_en),
    .tick_c  (step_tick)
  );

  // Saturating travel: steps past either end are swallowed.
  always_comb begin
    nxt_pos = position;
    if (step_tick) begin
      if ((state == RISING) && (position < PW'(TRAVEL))) begin
        nxt_pos = position + PW'(1);
      end else if ((state == FALLING) && (position != '0)) begin
        nxt_pos = position - PW'(1);
      end
    end
  end

  // Flags derive from next values so they always agree with the registered position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      position <= '0;
      Up_Max   <= 1'b0;
      Dn_Max   <= 1'b1;
      moving   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= nxt_state;
      position <= nxt_pos;
      Up_Max   <= (nxt_pos == PW'(TRAVEL));
      Dn_Max   <= (nxt_pos == '0);
      moving   <= (nxt_state == RISING) || (nxt_state == FALLING);
      fault    <= (nxt_state == FAULT);
    end
  end

endmodule
